// File: rtl/trace_pkg.sv
// trace_pkg -- definitions shared by the pipeline trace buffer files.
//   STAMP_W            : width of the free-running cycle stamp kept in each entry
//   ST_IDLE .. ST_DONE : capture state encoding, also driven on the 'state' port
package trace_pkg;

  localparam int STAMP_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/trace_ram.sv
// trace_ram -- DEPTH x EW storage for the trace buffer.
// One write port and one read port. The read data is registered, so it
// appears one clock after the address. Contents have no reset.
// Ports:
//   clock     in   rising-edge clock
//   wr_en     in   write wr_data at wr_addr this cycle
//   wr_addr   in   AW-bit write address
//   wr_data   in   EW-bit entry
//   rd_addr   in   AW-bit read address
//   rd_data   out  EW-bit entry at rd_addr, registered
module trace_ram #(
  parameter int DEPTH = 32,
  parameter int EW    = 84,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [EW-1:0] rd_data
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] rd_data_q;

  // Plain array with a registered read, so synthesis can map it to block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer -- circular trace of pipeline stage contents around a
// trigger event.
// Each sampled cycle stores {cycle_stamp, stage_valid, stage_data}. After
// the trigger, POST_TRIG more samples are recorded and then capture stops.
// Once capture is DONE, entries are read out oldest first.
// Optional feature: define PIPE_TRACE_MATCH_TRIG_EN to add the trig_value
// and trig_mask inputs. A valid stage-0 value that matches them under the
// mask also acts as a trigger.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   arm          in   start or restart a capture (one-cycle pulse)
//   sample_en    in   record this cycle's stage data
//   stage_data   in   STAGES*WIDTH bits; stage s in [s*WIDTH +: WIDTH]
//   stage_valid  in   per-stage valid bits
//   trig_in      in   external trigger
//   trig_value   in   (optional) stage-0 match value
//   trig_mask    in   (optional) stage-0 match mask
//   rd_idx       in   readout index, 0 = oldest retained entry
//   rd_data      out  selected entry, one-cycle latency; 0 unless DONE and in range
//   state        out  0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count        out  retained entries, saturating at DEPTH
//   trig_pos     out  index of the triggering entry, valid in DONE
module pipe_trace_buffer
  import trace_pkg::*;
#(
  parameter int STAGES    = 4,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int POST_TRIG = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                arm,
  input  logic                                sample_en,
  input  logic [STAGES*WIDTH-1:0]             stage_data,
  input  logic [STAGES-1:0]                   stage_valid,
  input  logic                                trig_in,
`ifdef PIPE_TRACE_MATCH_TRIG_EN
  input  logic [WIDTH-1:0]                    trig_value,
  input  logic [WIDTH-1:0]                    trig_mask,
`endif
  input  logic [$clog2(DEPTH)-1:0]            rd_idx,
  output logic [STAGES*WIDTH+STAGES+STAMP_W-1:0] rd_data,
  output logic [1:0]                          state,
  output logic [$clog2(DEPTH):0]              count,
  output logic [$clog2(DEPTH)-1:0]            trig_pos
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = STAGES*WIDTH + STAGES + STAMP_W;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_C  = AW'(POST_TRIG);

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [AW-1:0]      trig_addr_q, trig_addr_d;
  logic [AW-1:0]      post_q, post_d;
  logic               pend_q, pend_d;
  logic [STAMP_W-1:0] cyc_q, cyc_d;
  logic               rd_valid_q, rd_valid_d;

  logic               trig;
  logic               wr_en;
  logic [AW-1:0]      oldest;
  logic [EW-1:0]      ram_rd_data;

`ifdef PIPE_TRACE_MATCH_TRIG_EN
  assign trig = trig_in |
                (stage_valid[0] &
                 ((stage_data[WIDTH-1:0] & trig_mask) == (trig_value & trig_mask)));
`else
  assign trig = trig_in;
`endif

  // Until the buffer wraps, the oldest entry is slot 0. After it wraps, the
  // next slot to be overwritten holds the oldest entry.
  assign oldest = (count_q == DEPTH_C) ? wr_ptr_q : '0;

  // The write condition mirrors the sample branch of the state logic below.
  assign wr_en = reset && !arm && sample_en &&
                 ((state_q == ST_ARMED) || (state_q == ST_POST));

  // Next-state logic for the capture controller, the cycle stamp and the
  // readout gate. Reset is synchronous and overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    trig_addr_d = trig_addr_q;
    post_d      = post_q;
    pend_d      = pend_q;
    cyc_d       = cyc_q + 1'b1;
    // Sampled together with the RAM read address so that the gate lines up
    // with the registered RAM output.
    rd_valid_d  = (state_q == ST_DONE) && ({1'b0, rd_idx} < count_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d  = ST_ARMED;
          wr_ptr_d = '0;
          count_d  = '0;
          pend_d   = 1'b0;
        end
      end
      default: begin
        if (arm) begin
          // arm beats a trigger in the same cycle.
          state_d  = ST_ARMED;
          wr_ptr_d = '0;
          count_d  = '0;
          pend_d   = 1'b0;
        end else if (sample_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (count_q != DEPTH_C) begin
            count_d = count_q + 1'b1;
          end
          if (state_q == ST_ARMED) begin
            if (trig || pend_q) begin
              trig_addr_d = wr_ptr_q;
              pend_d      = 1'b0;
              post_d      = POST_C;
              state_d     = (POST_TRIG == 0) ? ST_DONE : ST_POST;
            end
          end else begin
            post_d = post_q - 1'b1;
            if (post_q == AW'(1)) begin
              state_d = ST_DONE;
            end
          end
        end else if ((state_q == ST_ARMED) && trig) begin
          // A trigger seen while the pipeline is frozen is held until the next
          // sampled cycle, so that the trigger lands on a real entry.
          pend_d = 1'b1;
        end
      end
    endcase

    if (!reset) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      count_d     = '0;
      trig_addr_d = '0;
      post_d      = '0;
      pend_d      = 1'b0;
      cyc_d       = '0;
      rd_valid_d  = 1'b0;
    end
  end

  // State registers. Reset values come from the combinational block above.
  always_ff @(posedge clock) begin
    state_q     <= state_d;
    wr_ptr_q    <= wr_ptr_d;
    count_q     <= count_d;
    trig_addr_q <= trig_addr_d;
    post_q      <= post_d;
    pend_q      <= pend_d;
    cyc_q       <= cyc_d;
    rd_valid_q  <= rd_valid_d;
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .EW    (EW),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data ({cyc_q, stage_valid, stage_data}),
    .rd_addr (oldest + rd_idx),
    .rd_data (ram_rd_data)
  );

  assign rd_data  = rd_valid_q ? ram_rd_data : '0;
  assign state    = state_q;
  assign count    = count_q;
  // The trigger slot is stored as a physical address. Its position is taken
  // relative to the current oldest entry, so it stays correct after a wrap.
  assign trig_pos = (state_q == ST_DONE) ? (trig_addr_q - oldest) : '0;

endmodule
